// File: rtl/logs_sweep_sequencer.sv
// rtl/logs_sweep_sequencer.sv - r sweep, settle, oscillator-load and dwell sequencer for the logistic-map sonifier
module logs_sweep_sequencer #(
  parameter int              N_OSC  = 4,
  parameter int              FRAC   = 8,
  parameter int              SETTLE = 64,
  parameter int              DWELL  = 30000,
  parameter logic [FRAC+1:0] R_INIT = 'h110,
  parameter int              R_STEP = 1,
  parameter logic [FRAC+1:0] R_MAX  = 'h3FF
) (
  input  logic                                          clk,
  input  logic                                          reset,
  input  logic                                          enable,
  input  logic                                          hold,
  output logic [FRAC+1:0]                               r,
  output logic                                          x_seed,
  output logic                                          load_en,
  output logic [((N_OSC > 1) ? $clog2(N_OSC) : 1)-1:0]  load_idx,
  output logic                                          wrap,
  output logic                                          busy
);

  localparam int IW      = (N_OSC > 1) ? $clog2(N_OSC) : 1;
  localparam int CNT_MAX = (SETTLE > DWELL) ? ((SETTLE > N_OSC) ? SETTLE : N_OSC)
                                            : ((DWELL > N_OSC) ? DWELL : N_OSC);
  localparam int CW      = $clog2(CNT_MAX + 1);

  localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE - 1);
  localparam logic [CW-1:0] LOAD_LAST   = CW'(N_OSC - 1);
  localparam logic [CW-1:0] DWELL_LAST  = CW'(DWELL - 1);

  typedef enum logic [2:0] {S_IDLE, S_SETTLE, S_LOAD, S_DWELL, S_STEP} state_t;

  state_t          state, next_state;
  logic [CW-1:0]   cnt, next_cnt;
  logic [FRAC+2:0] r_sum;
  logic            r_over;
  logic [FRAC+1:0] r_d;
  logic            x_seed_d, load_en_d, wrap_d, busy_d;
  logic [IW-1:0]   load_idx_d;

  // One extra bit so an increment past the top of the r range is detectable.
  assign r_sum  = {1'b0, r} + (FRAC+3)'(R_STEP);
  assign r_over = r_sum > {1'b0, R_MAX};

  // State and shared counter register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= next_state;
      cnt   <= next_cnt;
    end
  end

  // Next-state and counter logic; enable low returns to IDLE from anywhere.
  always_comb begin
    next_state = state;
    next_cnt   = cnt + CW'(1);
    if (!enable) begin
      next_state = S_IDLE;
      next_cnt   = '0;
    end else begin
      case (state)
        S_IDLE: begin
          next_state = S_SETTLE;
          next_cnt   = '0;
        end
        S_SETTLE: begin
          if (cnt == SETTLE_LAST) begin
            next_state = S_LOAD;
            next_cnt   = '0;
          end
        end
        S_LOAD: begin
          if (cnt == LOAD_LAST) begin
            next_state = S_DWELL;
            next_cnt   = '0;
          end
        end
        S_DWELL: begin
          // hold only matters here: it restarts the dwell instead of stepping r.
          if (cnt == DWELL_LAST) begin
            next_state = hold ? S_DWELL : S_STEP;
            next_cnt   = '0;
          end
        end
        S_STEP: begin
          next_state = S_SETTLE;
          next_cnt   = '0;
        end
        default: begin
          next_state = S_IDLE;
          next_cnt   = '0;
        end
      endcase
    end
  end

  // Output decode from the upcoming state so every output comes straight off a flop.
  always_comb begin
    r_d        = r;
    x_seed_d   = 1'b0;
    load_en_d  = 1'b0;
    load_idx_d = '0;
    wrap_d     = 1'b0;
    busy_d     = (next_state != S_IDLE);
    if (next_state == S_LOAD) begin
      load_en_d  = 1'b1;
      load_idx_d = next_cnt[IW-1:0];
    end
    if (next_state == S_STEP) begin
      x_seed_d = 1'b1;
    end
    // r moves when leaving STEP, so wrap lands together with the reloaded r,
    // one cycle after x_seed.
    if (state == S_STEP && enable) begin
      if (r_over) begin
        r_d    = R_INIT;
        wrap_d = 1'b1;
      end else begin
        r_d = r_sum[FRAC+1:0];
      end
    end
  end

  // Output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r        <= R_INIT;
      x_seed   <= 1'b0;
      load_en  <= 1'b0;
      load_idx <= '0;
      wrap     <= 1'b0;
      busy     <= 1'b0;
    end else begin
      r        <= r_d;
      x_seed   <= x_seed_d;
      load_en  <= load_en_d;
      load_idx <= load_idx_d;
      wrap     <= wrap_d;
      busy     <= busy_d;
    end
  end

endmodule

// File: tb/tb_logs_sweep_sequencer.sv
// tb/tb_logs_sweep_sequencer.sv - directed and reference-model checks of logs_sweep_sequencer
module tb_logs_sweep_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, enable, hold;
  logic [9:0] r, rw;
  logic       x_seed, load_en, wrap, busy;
  logic       x_seedw, load_enw, wrapw, busyw;
  logic [1:0] load_idx, load_idxw;

  int n_cmp  = 0;
  int n_fail = 0;

  // Main instance: full r range.
  logs_sweep_sequencer #(
    .N_OSC(4), .FRAC(8), .SETTLE(4), .DWELL(8),
    .R_INIT(10'h110), .R_STEP(1), .R_MAX(10'h3FF)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .hold(hold),
    .r(r), .x_seed(x_seed), .load_en(load_en), .load_idx(load_idx),
    .wrap(wrap), .busy(busy)
  );

  // Short-sweep instance: wraps after three r values.
  logs_sweep_sequencer #(
    .N_OSC(4), .FRAC(8), .SETTLE(4), .DWELL(8),
    .R_INIT(10'h110), .R_STEP(1), .R_MAX(10'h112)
  ) dut_w (
    .clk(clk), .reset(reset), .enable(enable), .hold(hold),
    .r(rw), .x_seed(x_seedw), .load_en(load_enw), .load_idx(load_idxw),
    .wrap(wrapw), .busy(busyw)
  );

  // Reference model of the short-sweep instance, expressed as a position within one r period:
  // 0 idle, 1..4 settle, 5..8 load, 9..16 dwell, 17 step.
  localparam int MS     = 4;
  localparam int MN     = 4;
  localparam int MD     = 8;
  localparam int P_STEP = MS + MN + MD + 1;

  int         m_pos  = 0;
  logic [9:0] m_r    = 10'h110;
  logic       m_wrap = 1'b0;

  always @(posedge clk) begin
    m_wrap <= 1'b0;
    if (reset) begin
      m_pos <= 0;
      m_r   <= 10'h110;
    end else if (!enable) begin
      m_pos <= 0;
    end else if (m_pos == 0) begin
      m_pos <= 1;
    end else if (m_pos == P_STEP) begin
      m_pos <= 1;
      if (m_r >= 10'h112) begin
        m_r    <= 10'h110;
        m_wrap <= 1'b1;
      end else begin
        m_r <= m_r + 10'd1;
      end
    end else if (m_pos == MS + MN + MD && hold) begin
      m_pos <= MS + MN + 1;
    end else begin
      m_pos <= m_pos + 1;
    end
  end

  task automatic do_reset();
    reset  = 1'b1;
    enable = 1'b0;
    hold   = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    logic [15:0] got;
    reset  = 1'b1;
    enable = 1'b1;
    hold   = 1'b1;
    repeat (3) @(negedge clk);
    got = {busy, load_en, load_idx, x_seed, wrap, r};
    n_cmp++;
    if (got !== {6'b000000, 10'h110}) begin
      n_fail++;
      $display("FAIL reset_state: got %h expected %h", got, {6'b000000, 10'h110});
    end
    got = {busyw, load_enw, load_idxw, x_seedw, wrapw, rw};
    n_cmp++;
    if (got !== {6'b000000, 10'h110}) begin
      n_fail++;
      $display("FAIL reset_state_w: got %h expected %h", got, {6'b000000, 10'h110});
    end
    reset  = 1'b0;
    enable = 1'b0;
    hold   = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_after_reset: busy got %b expected 0", busy);
    end
  endtask

  task automatic test_first_period();
    logic [15:0] got, exp;
    logic        e_ld;
    logic [1:0]  e_idx;
    do_reset();
    enable = 1'b1;
    for (int c = 1; c <= 18; c++) begin
      @(negedge clk);
      e_ld  = (c >= 5 && c <= 8);
      e_idx = e_ld ? 2'(c - 5) : 2'd0;
      exp   = {1'b1, e_ld, e_idx, (c == 17), 1'b0, (c >= 18) ? 10'h111 : 10'h110};
      got   = {busy, load_en, load_idx, x_seed, wrap, r};
      n_cmp++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL first_period c=%0d: got %h expected %h", c, got, exp);
      end
    end
  endtask

  task automatic test_sweep_wrap();
    logic [11:0] got, exp;
    logic [9:0]  e_r;
    do_reset();
    enable = 1'b1;
    for (int c = 1; c <= 56; c++) begin
      @(negedge clk);
      e_r = (c < 18) ? 10'h110 : (c < 35) ? 10'h111 : (c < 52) ? 10'h112 : 10'h110;
      exp = {(c == 17 || c == 34 || c == 51), (c == 52), e_r};
      got = {x_seedw, wrapw, rw};
      n_cmp++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL sweep_wrap c=%0d: got %h expected %h", c, got, exp);
      end
    end
  endtask

  task automatic test_hold();
    logic [12:0] got, exp;
    do_reset();
    hold   = 1'b1;
    enable = 1'b1;
    for (int c = 1; c <= 42; c++) begin
      @(negedge clk);
      exp = {1'b1, (c >= 5 && c <= 8), (c == 41), (c >= 42) ? 10'h111 : 10'h110};
      got = {busy, load_en, x_seed, r};
      n_cmp++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL hold c=%0d: got %h expected %h", c, got, exp);
      end
      if (c == 34) hold = 1'b0;
    end
  endtask

  task automatic test_enable_drop();
    logic [14:0] got, exp;
    logic        e_busy, e_ld;
    logic [1:0]  e_idx;
    do_reset();
    enable = 1'b1;
    for (int c = 1; c <= 16; c++) begin
      @(negedge clk);
      e_busy = !(c == 7 || c == 8);
      e_ld   = (c == 5 || c == 6) || (c >= 13);
      e_idx  = (c == 5 || c == 6) ? 2'(c - 5) : (c >= 13) ? 2'(c - 13) : 2'd0;
      exp    = {e_busy, e_ld, e_idx, 1'b0, 10'h110};
      got    = {busy, load_en, load_idx, x_seed, r};
      n_cmp++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL enable_drop c=%0d: got %h expected %h", c, got, exp);
      end
      if (c == 6) enable = 1'b0;
      if (c == 8) enable = 1'b1;
    end
  endtask

  task automatic test_reset_mid_dwell();
    logic [15:0] got;
    do_reset();
    enable = 1'b1;
    for (int c = 1; c <= 98; c++) begin
      @(negedge clk);
      got = {busy, load_en, load_idx, x_seed, wrap, r};
      if (c == 96) begin
        n_cmp++;
        if (got !== {6'b100000, 10'h115}) begin
          n_fail++;
          $display("FAIL pre_reset_dwell: got %h expected %h", got, {6'b100000, 10'h115});
        end
        reset = 1'b1;
      end
      if (c >= 97) begin
        n_cmp++;
        if (got !== {6'b000000, 10'h110}) begin
          n_fail++;
          $display("FAIL reset_mid_dwell c=%0d: got %h expected %h", c, got, {6'b000000, 10'h110});
        end
      end
    end
    reset  = 1'b0;
    enable = 1'b0;
  endtask

  task automatic test_random();
    logic [15:0] got, exp;
    logic        e_ld;
    logic [9:0]  prev_r;
    int          lc;
    bit          disturbed;
    do_reset();
    prev_r    = 10'h110;
    lc        = 0;
    disturbed = 1'b0;
    enable    = 1'b1;
    for (int c = 1; c <= 20000; c++) begin
      @(negedge clk);
      e_ld = (m_pos >= MS + 1 && m_pos <= MS + MN);
      exp  = {(m_pos != 0), e_ld, e_ld ? 2'(m_pos - MS - 1) : 2'd0,
              (m_pos == P_STEP), m_wrap, m_r};
      got  = {busyw, load_enw, load_idxw, x_seedw, wrapw, rw};
      n_cmp++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL rand_model c=%0d: got %h expected %h", c, got, exp);
      end
      n_cmp++;
      if ($countones({x_seedw, wrapw, load_enw}) > 1 || $countones({x_seed, wrap, load_en}) > 1) begin
        n_fail++;
        $display("FAIL rand_pulse_excl c=%0d: got %b/%b expected at most one high",
                 c, {x_seedw, wrapw, load_enw}, {x_seed, wrap, load_en});
      end
      n_cmp++;
      if (rw < 10'h110 || rw > 10'h112 || r < 10'h110) begin
        n_fail++;
        $display("FAIL rand_r_range c=%0d: got %h/%h expected within range", c, rw, r);
      end
      if (load_enw) lc++;
      if (rw !== prev_r) begin
        if (!disturbed) begin
          n_cmp++;
          if (lc != MN) begin
            n_fail++;
            $display("FAIL rand_loads_per_r c=%0d: got %0d expected %0d", c, lc, MN);
          end
        end
        prev_r    = rw;
        lc        = 0;
        disturbed = 1'b0;
      end
      enable = ($urandom_range(0, 99) < 97);
      hold   = ($urandom_range(0, 99) < 40);
      if (!enable) disturbed = 1'b1;
    end
    enable = 1'b0;
    hold   = 1'b0;
  endtask

  initial begin
    reset  = 1'b1;
    enable = 1'b0;
    hold   = 1'b0;
    test_reset();
    test_first_period();
    test_sweep_wrap();
    test_hold();
    test_enable_drop();
    test_reset_mid_dwell();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
